// File: rtl/forward_quantizer.sv
// JPEG encoder quantizer: divides 8x8 DCT coefficient columns by Annex K steps through a 3-stage pipeline.
// Define QUANT_CHROMA_EN to add the table_sel_in port and the chroma table; otherwise only the luma table is built.
module forward_quantizer (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [95:0] column_in,
  input  logic        valid_in,
  output logic        ready_out,
`ifdef QUANT_CHROMA_EN
  input  logic        table_sel_in,
`endif
  output logic [95:0] column_out,
  output logic [2:0]  col_out,
  output logic        last_out,
  output logic        valid_out,
  input  logic        ready_in
);

  localparam int LUMA_Q [8][8] = '{
    '{16, 11, 10, 16,  24,  40,  51,  61},
    '{12, 12, 14, 19,  26,  58,  60,  55},
    '{14, 13, 16, 24,  40,  57,  69,  56},
    '{14, 17, 22, 29,  51,  87,  80,  62},
    '{18, 22, 37, 56,  68, 109, 103,  77},
    '{24, 35, 55, 64,  81, 104, 113,  92},
    '{49, 64, 78, 87, 103, 121, 120, 101},
    '{72, 92, 95, 98, 112, 100, 103,  99}
  };

  localparam int CHROMA_TL [4][4] = '{
    '{17, 18, 24, 47},
    '{18, 21, 26, 66},
    '{24, 26, 56, 99},
    '{47, 66, 99, 99}
  };

  function automatic int q_step(input bit chroma, input int i, input int j);
    if (!chroma) return LUMA_Q[i][j];
    if (i < 4 && j < 4) return CHROMA_TL[i][j];
    return 99;
  endfunction

  // Reciprocal ROM indexed {row, column}; no exact ties exist, so floor((65536 + q/2) / q) is round-to-nearest.
  function automatic logic [63:0][12:0] build_recip(input bit chroma);
    logic [63:0][12:0] t;
    int q;
    t = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        q = q_step(chroma, i, j);
        t[i*8+j] = 13'((65536 + q / 2) / q);
      end
    end
    return t;
  endfunction

  localparam logic [63:0][12:0] LUMA_R = build_recip(1'b0);
`ifdef QUANT_CHROMA_EN
  localparam logic [63:0][12:0] CHROMA_R = build_recip(1'b1);
`endif

  logic        en;
  logic        accept;
  logic [2:0]  col_cnt;

  logic [11:0] lane_in   [8];
  logic [11:0] mag_in    [8];
  logic [12:0] recip_sel [8];

  logic        s1_valid;
  logic [11:0] s1_mag    [8];
  logic [7:0]  s1_sign;
  logic [12:0] s1_recip  [8];
  logic [2:0]  s1_col;

  logic        s2_valid;
  logic [24:0] s2_prod   [8];
  logic [7:0]  s2_sign;
  logic [2:0]  s2_col;

  logic [24:0] rnd       [8];
  logic [11:0] q_mag     [8];
  logic [11:0] q_val     [8];

  // NOTE: ready_out is combinational from the registered valid_out so a stalled
  // output freezes every stage in the same cycle, with no skid buffer needed.
  assign en        = !valid_out || ready_in;
  assign ready_out = en;
  assign accept    = valid_in && en;

`ifdef QUANT_CHROMA_EN
  logic tbl_chroma;
  logic use_chroma;
  // Column 0 takes the select live; the rest of the block reuses the latched choice.
  assign use_chroma = (col_cnt == 3'd0) ? table_sel_in : tbl_chroma;
`endif

  // NOTE: every signal written in an always_comb is assigned on every path, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      lane_in[i] = column_in[12*i +: 12];
      mag_in[i]  = lane_in[i][11] ? -lane_in[i] : lane_in[i];
`ifdef QUANT_CHROMA_EN
      recip_sel[i] = use_chroma ? CHROMA_R[{3'(i), col_cnt}] : LUMA_R[{3'(i), col_cnt}];
`else
      recip_sel[i] = LUMA_R[{3'(i), col_cnt}];
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      rnd[i]   = s2_prod[i] + 25'd32768;
      q_mag[i] = {3'b000, rnd[i][24:16]};
      q_val[i] = s2_sign[i] ? -q_mag[i] : q_mag[i];
    end
  end

  // NOTE: the data pipeline carries no reset; the stage valids alone decide what is meaningful,
  // which keeps reset fan-out off the wide datapath.
  always_ff @(posedge clk_in) begin
    if (en) begin
      for (int i = 0; i < 8; i++) begin
        s1_mag[i]   <= mag_in[i];
        s1_sign[i]  <= lane_in[i][11];
        s1_recip[i] <= recip_sel[i];
        s2_prod[i]  <= 25'(s1_mag[i]) * 25'(s1_recip[i]);
      end
      s1_col  <= col_cnt;
      s2_sign <= s1_sign;
      s2_col  <= s1_col;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      valid_out  <= 1'b0;
      col_cnt    <= 3'd0;
      col_out    <= 3'd0;
      last_out   <= 1'b0;
      column_out <= '0;
`ifdef QUANT_CHROMA_EN
      tbl_chroma <= 1'b0;
`endif
    end else if (en) begin
      s1_valid  <= accept;
      s2_valid  <= s1_valid;
      valid_out <= s2_valid;
      if (accept) begin
        col_cnt <= col_cnt + 3'd1;
`ifdef QUANT_CHROMA_EN
        if (col_cnt == 3'd0) tbl_chroma <= table_sel_in;
`endif
      end
      col_out  <= s2_col;
      last_out <= (s2_col == 3'd7);
      for (int i = 0; i < 8; i++) begin
        column_out[12*i +: 12] <= q_val[i];
      end
    end
  end

endmodule

// File: tb/tb_forward_quantizer.sv
// Directed bench for forward_quantizer: hand-computed quotients, rounding ties, wrap, stall, mid-block reset, table select.
module tb_forward_quantizer;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [95:0] column_in = '0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic        table_sel_in = 1'b0;
  logic [95:0] column_out;
  logic [2:0]  col_out;
  logic        last_out;
  logic        valid_out;
  logic        ready_in = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  int q_row0 [8] = '{16, 11, 10, 16, 24, 40, 51, 61};
  int q_row7 [8] = '{72, 92, 95, 98, 112, 100, 103, 99};

  always #5 clk_in = ~clk_in;

  forward_quantizer dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .column_in   (column_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
`ifdef QUANT_CHROMA_EN
    .table_sel_in(table_sel_in),
`endif
    .column_out  (column_out),
    .col_out     (col_out),
    .last_out    (last_out),
    .valid_out   (valid_out),
    .ready_in    (ready_in)
  );

  function automatic logic [95:0] put(input logic [95:0] base, input int lane, input int val);
    logic [95:0] r;
    logic [11:0] v;
    r = base;
    v = val[11:0];
    r[12*lane +: 12] = v;
    return r;
  endfunction

  // Feeds one whole block back-to-back with ready_in high and collects up to 8 outputs.
  task automatic run_block(input logic [95:0] cols [8], input logic sels [8],
                           output logic [95:0] outs [8], output logic [2:0] idx [8],
                           output logic lasts [8], output int got, output int first_cyc);
    int g;
    int fc;
    g  = 0;
    fc = -1;
    for (int k = 0; k < 8; k++) begin
      outs[k]  = '0;
      idx[k]   = '0;
      lasts[k] = 1'b0;
    end
    ready_in = 1'b1;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          @(negedge clk_in);
          column_in    = cols[k];
          table_sel_in = sels[k];
          valid_in     = 1'b1;
        end
        @(negedge clk_in);
        valid_in = 1'b0;
      end
      begin
        for (int c = 0; c < 40 && g < 8; c++) begin
          @(negedge clk_in);
          #1;
          if (valid_out) begin
            if (g == 0) fc = c;
            outs[g]  = column_out;
            idx[g]   = col_out;
            lasts[g] = last_out;
            g++;
          end
        end
      end
    join
    got       = g;
    first_cyc = fc;
  endtask

  task automatic test_reset();
    rst_in   = 1'b0;
    valid_in = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    #1;
    n_cmp++;
    if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
    n_cmp++;
    if (col_out !== 3'd0) begin n_bad++; $display("FAIL reset_col_out: got %0d want 0", col_out); end
    n_cmp++;
    if (last_out !== 1'b0) begin n_bad++; $display("FAIL reset_last_out: got %b want 0", last_out); end
    n_cmp++;
    if (column_out !== 96'd0) begin n_bad++; $display("FAIL reset_column_out: got %h want 0", column_out); end
    rst_in = 1'b1;
    @(negedge clk_in);
    #1;
    n_cmp++;
    if (ready_out !== 1'b1) begin n_bad++; $display("FAIL reset_ready_out: got %b want 1", ready_out); end
  endtask

  task automatic test_basic();
    logic [95:0] cols [8];
    logic        sels [8];
    logic [95:0] outs [8];
    logic [2:0]  idx  [8];
    logic        lasts[8];
    int got, fc;
    for (int k = 0; k < 8; k++) begin cols[k] = '0; sels[k] = 1'b0; end
    cols[0] = put(put(96'd0, 0, 100), 1, -24);
    run_block(cols, sels, outs, idx, lasts, got, fc);
    n_cmp++;
    if (got !== 8) begin n_bad++; $display("FAIL basic_count: got %0d want 8", got); end
    n_cmp++;
    if (fc !== 3) begin n_bad++; $display("FAIL basic_latency: got %0d want 3", fc); end
    n_cmp++;
    if (outs[0] !== put(put(96'd0, 0, 6), 1, -2))
      begin n_bad++; $display("FAIL basic_col0: got %h want %h", outs[0], put(put(96'd0, 0, 6), 1, -2)); end
    n_cmp++;
    if (idx[0] !== 3'd0 || lasts[0] !== 1'b0)
      begin n_bad++; $display("FAIL basic_tag: got col %0d last %b want col 0 last 0", idx[0], lasts[0]); end
    n_cmp++;
    if (outs[1] !== 96'd0 || idx[1] !== 3'd1)
      begin n_bad++; $display("FAIL basic_zero_col: got %h col %0d want 0 col 1", outs[1], idx[1]); end
  endtask

  task automatic test_rounding();
    int vals [3] = '{5, 4, -5};
    int exps [3] = '{1, 0, -1};
    logic [95:0] cols [8];
    logic        sels [8];
    logic [95:0] outs [8];
    logic [2:0]  idx  [8];
    logic        lasts[8];
    int got, fc;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 8; k++) begin cols[k] = '0; sels[k] = 1'b0; end
      cols[2] = put(96'd0, 0, vals[b]);
      run_block(cols, sels, outs, idx, lasts, got, fc);
      n_cmp++;
      if (got !== 8 || outs[2] !== put(96'd0, 0, exps[b]) || idx[2] !== 3'd2)
        begin n_bad++; $display("FAIL round_%0d: got n=%0d %h col %0d want n=8 %h col 2",
                                vals[b], got, outs[2], idx[2], put(96'd0, 0, exps[b])); end
    end
  endtask

  task automatic test_wrap();
    logic [95:0] cols [8];
    logic        sels [8];
    logic [95:0] outs [8];
    logic [2:0]  idx  [8];
    logic        lasts[8];
    int got, fc;
    for (int k = 0; k < 8; k++) begin cols[k] = '0; sels[k] = 1'b0; end
    cols[7] = put(put(96'd0, 7, 2047), 0, -2048);
    run_block(cols, sels, outs, idx, lasts, got, fc);
    n_cmp++;
    if (outs[7] !== put(put(96'd0, 7, 21), 0, -34))
      begin n_bad++; $display("FAIL wrap_extremes: got %h want %h", outs[7], put(put(96'd0, 7, 21), 0, -34)); end
    n_cmp++;
    if (idx[7] !== 3'd7 || lasts[7] !== 1'b1)
      begin n_bad++; $display("FAIL wrap_last: got col %0d last %b want col 7 last 1", idx[7], lasts[7]); end
    n_cmp++;
    if (lasts[6] !== 1'b0) begin n_bad++; $display("FAIL wrap_last_early: got %b want 0", lasts[6]); end
    for (int k = 0; k < 8; k++) cols[k] = '0;
    run_block(cols, sels, outs, idx, lasts, got, fc);
    n_cmp++;
    if (got !== 8 || idx[0] !== 3'd0 || lasts[0] !== 1'b0)
      begin n_bad++; $display("FAIL wrap_next_col: got n=%0d col %0d last %b want n=8 col 0 last 0", got, idx[0], lasts[0]); end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    int stall = 0;
    int cyc = 0;
    logic [95:0] held = '0;
    logic [2:0]  held_col = '0;
    logic [95:0] exp_col;
    while (got < 8 && cyc < 60) begin
      @(negedge clk_in);
      ready_in = (stall > 0) ? 1'b0 : 1'b1;
      if (sent < 8) begin
        column_in = put(put(96'd0, 0, q_row0[sent] * (sent + 1)), 7, -q_row7[sent]);
        valid_in  = 1'b1;
      end else begin
        valid_in = 1'b0;
      end
      #1;
      if (stall > 0) begin
        if (stall == 4) begin
          held     = column_out;
          held_col = col_out;
          n_cmp++;
          if ({valid_out, ready_out} !== 2'b10)
            begin n_bad++; $display("FAIL stall_ready: got valid %b ready %b want 1 0", valid_out, ready_out); end
        end else begin
          n_cmp++;
          if (column_out !== held || col_out !== held_col || valid_out !== 1'b1 || ready_out !== 1'b0)
            begin n_bad++; $display("FAIL stall_hold: got %h col %0d v %b r %b want %h col %0d v 1 r 0",
                                    column_out, col_out, valid_out, ready_out, held, held_col); end
        end
        stall--;
      end
      if (valid_in && ready_out) sent++;
      if (valid_out && ready_in) begin
        exp_col = put(put(96'd0, 0, got + 1), 7, -1);
        n_cmp++;
        if (column_out !== exp_col || col_out !== 3'(got) || last_out !== (got == 7))
          begin n_bad++; $display("FAIL b2b_out%0d: got %h col %0d last %b want %h col %0d last %b",
                                  got, column_out, col_out, last_out, exp_col, got, (got == 7)); end
        got++;
        if (got == 2) stall = 4;
      end
      cyc++;
    end
    n_cmp++;
    if (got !== 8 || sent !== 8) begin n_bad++; $display("FAIL b2b_count: got out %0d in %0d want 8 8", got, sent); end
    ready_in = 1'b1;
    valid_in = 1'b0;
    @(negedge clk_in);
    #1;
    n_cmp++;
    if (valid_out !== 1'b0) begin n_bad++; $display("FAIL b2b_no_dup: got valid %b want 0", valid_out); end
  endtask

  task automatic test_reset_midblock();
    logic [95:0] cols [8];
    logic        sels [8];
    logic [95:0] outs [8];
    logic [2:0]  idx  [8];
    logic        lasts[8];
    int got, fc;
    int stray = 0;
    ready_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      column_in = put(96'd0, 0, 16 * (k + 1));
      valid_in  = 1'b1;
    end
    @(negedge clk_in);
    valid_in = 1'b0;
    rst_in   = 1'b0;
    @(negedge clk_in);
    #1;
    n_cmp++;
    if (valid_out !== 1'b0) begin n_bad++; $display("FAIL midreset_valid: got %b want 0", valid_out); end
    rst_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_in);
      #1;
      if (valid_out) stray++;
    end
    n_cmp++;
    if (stray !== 0) begin n_bad++; $display("FAIL midreset_drop: got %0d stray outputs want 0", stray); end
    for (int k = 0; k < 8; k++) begin cols[k] = '0; sels[k] = 1'b0; end
    cols[0] = put(96'd0, 0, 100);
    run_block(cols, sels, outs, idx, lasts, got, fc);
    n_cmp++;
    if (got !== 8 || idx[0] !== 3'd0 || outs[0] !== put(96'd0, 0, 6))
      begin n_bad++; $display("FAIL midreset_restart: got n=%0d col %0d %h want n=8 col 0 %h",
                              got, idx[0], outs[0], put(96'd0, 0, 6)); end
  endtask

  task automatic test_table();
    logic [95:0] cols [8];
    logic        sels [8];
    logic [95:0] outs [8];
    logic [2:0]  idx  [8];
    logic        lasts[8];
    int got, fc;
    for (int k = 0; k < 8; k++) begin cols[k] = '0; sels[k] = 1'b0; end
    cols[5] = put(96'd0, 0, 198);
    cols[7] = put(96'd0, 0, 198);
`ifdef QUANT_CHROMA_EN
    sels[0] = 1'b1;
    run_block(cols, sels, outs, idx, lasts, got, fc);
    n_cmp++;
    if (outs[5] !== put(96'd0, 0, 2)) begin n_bad++; $display("FAIL chroma_c5: got %h want %h", outs[5], put(96'd0, 0, 2)); end
    n_cmp++;
    if (outs[7] !== put(96'd0, 0, 2)) begin n_bad++; $display("FAIL chroma_c7: got %h want %h", outs[7], put(96'd0, 0, 2)); end
    sels[0] = 1'b0;
`endif
    run_block(cols, sels, outs, idx, lasts, got, fc);
    n_cmp++;
    if (outs[5] !== put(96'd0, 0, 5)) begin n_bad++; $display("FAIL luma_c5: got %h want %h", outs[5], put(96'd0, 0, 5)); end
    n_cmp++;
    if (outs[7] !== put(96'd0, 0, 3)) begin n_bad++; $display("FAIL luma_c7: got %h want %h", outs[7], put(96'd0, 0, 3)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_wrap();
    test_back_to_back();
    test_reset_midblock();
    test_table();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/forward_quantizer.md
# forward_quantizer

Encoder-side JPEG quantizer: accepts 8×8 DCT coefficient blocks one 8-lane column per transfer, divides each coefficient by its Annex K quantization step with round-half-away-from-zero, and emits quantized columns. Sits between the forward DCT column output and the zigzag/entropy stage. It is the exact counterpart of the decoder's inverse quantizer: same lane/column packing, same table orientation.

## Interface
- No parameters; widths fixed.
- clk_in  input  1  system clock
- rst_in  input  1  reset, synchronous, active-low
- column_in  input  96  8 signed 12-bit coefficients; lane i = bits [12i+11:12i] = row i
- valid_in  input  1  column_in valid
- ready_out  output  1  block can accept a column this cycle
- table_sel_in  input  1  0 = luma, 1 = chroma; present only with `QUANT_CHROMA_EN`
- column_out  output  96  8 signed 12-bit quantized values, same lane packing
- col_out  output  3  column index (0–7) of column_out
- last_out  output  1  high with col_out == 7
- valid_out  output  1  column_out valid
- ready_in  input  1  downstream accepts column_out

## Operation
- Transfer in: valid_in && ready_out. Transfer out: valid_out && ready_in.
- Column counter (3 bits) counts accepted columns, 0→7 then wraps to 0; column j of the block uses table column j. No other framing; upstream must deliver whole blocks.
- Luma table rows Q[i][0..7]: 16 11 10 16 24 40 51 61 / 12 12 14 19 26 58 60 55 / 14 13 16 24 40 57 69 56 / 14 17 22 29 51 87 80 62 / 18 22 37 56 68 109 103 77 / 24 35 55 64 81 104 113 92 / 49 64 78 87 103 121 120 101 / 72 92 95 98 112 100 103 99.
- Division is normative via reciprocal: R[i][j] = round(65536 / Q[i][j]) stored as 13-bit unsigned constants (max 6554).
- Per lane: m = |c| (12-bit unsigned, 2048 allowed); p = m·R (25-bit unsigned); q = (p + 32768) >> 16; output = sign(c) ? −q : q, 12-bit two's complement. c = 0 → 0. No saturation needed (|q| ≤ 205).
- Pipeline, 3 stages: S1 register abs values, sign bits, column index, selected reciprocals; S2 register 8 products; S3 round, shift, re-sign into column_out.
- Global advance enable en = !valid_out || ready_in; all stages and the counter move only when en; ready_out = en. Bubbles occupy stages.
- Output stall: while valid_out && !ready_in, column_out, col_out, last_out, valid_out held stable.

## Timing
- Latency: column accepted at edge N appears on column_out after edge N+3 when no stall; each stall cycle adds one.
- Throughput: one column per cycle with ready_in held high.
- Reset (rst_in == 0 at an edge): all stage valids, valid_out, counter, col_out, last_out, column_out → 0; table select → luma. ready_out is 1 the cycle after reset releases. Reset mid-block discards all in-flight columns; the next accepted column is column 0.
- valid_in with ready_out low: column not consumed, counter unchanged; upstream must hold data.
- Simultaneous input and output transfers in one cycle are normal and fully supported.

## Configuration
- `QUANT_CHROMA_EN` defined: table_sel_in port exists; sampled only on acceptance of column 0, held for columns 1–7 of that block (changes mid-block ignored). Chroma table: Q = 99 everywhere except top-left 4×4 rows 17 18 24 47 / 18 21 26 66 / 24 26 56 99 / 47 66 99 99; reciprocals by the same formula.
- Undefined: no table_sel_in port; luma table only; chroma ROM not synthesized.

## Test plan
- Column 0, lane 0 = 100, lane 1 = −24 (Q 16 and 12), ready_in high -> after 3 cycles lane 0 = 6, lane 1 = −2, col_out 0, last_out 0.
- Column 2 lane 0 (Q 10) inputs 5, 4, −5 in successive blocks -> 1, 0, −1 (half away from zero).
- Column 7 lane 7 = 2047, lane 0 = −2048 (Q 99, 61) -> 21 and −34; last_out 1; counter wraps so next column reports col_out 0.
- 8 back-to-back columns with ready_in low for 4 cycles after the second output -> ready_out drops, outputs held stable, no loss/duplication, order preserved.
- Reset asserted after column 3 accepted -> valid_out 0 next cycle, in-flight data dropped, following column tagged col_out 0.
- With `QUANT_CHROMA_EN`: table_sel_in = 1 at column 0 then toggled to 0 -> all 8 columns use chroma (column 5 lane 0 = 198 -> 2), next block with table_sel_in = 0 uses luma (198/40 -> 5).
